// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
package mem_arb_pkg;

   // Arbiter sequencing: accept, strobe, wait for memory, respond
   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   // Which requester owns the transaction in flight
   typedef enum logic {
      OWN_INSTR,
      OWN_DATA
   } owner_t;

   // Fetches always read a full word
   localparam logic [3:0] FETCH_SEL = 4'b1111;

   // Timeout counter width, enough for TIMEOUT_CYCLES up to 65535
   localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/mem_arb_timeout_cnt.sv
// mem_arb_timeout_cnt: counts WAIT cycles and flags the cycle in which the
// count reaches TIMEOUT_CYCLES.
module mem_arb_timeout_cnt
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [CNT_W-1:0] count;

   // Cycle counter: cleared on reset or clr, advances while enabled
   always_ff @(posedge sys_clk) begin
      if (!rst_n || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   // tc marks the enabled cycle whose increment would reach TIMEOUT_CYCLES
   assign tc = en && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one pipelined Wishbone master between an
// instruction-fetch port and a data port, one transaction in flight.
// Build option: define ARB_ROUND_ROBIN_EN to break ties round-robin;
// otherwise the data port has fixed priority.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   // instruction fetch port
   input  logic        i_stb,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   output logic        i_err,
   // data port
   input  logic        d_stb,
   input  logic        d_we,
   input  logic [3:0]  d_sel,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_err,
   // shared memory master
   output logic        m_cyc,
   output logic        m_stb,
   output logic        m_we,
   output logic [3:0]  m_sel,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   input  logic        m_ack
);

   arb_state_t state;
   owner_t     owner;
   owner_t     winner;
   logic       cnt_clr;
   logic       cnt_en;
   logic       cnt_tc;
   logic       done;
   logic       done_err;
`ifdef ARB_ROUND_ROBIN_EN
   owner_t     last_grant;
`endif

   assign cnt_clr  = (state == ISSUE);
   assign cnt_en   = (state == WAIT);
   // m_ack in the final WAIT cycle takes precedence over the timeout
   assign done     = ((state == ISSUE) && m_ack) ||
                     ((state == WAIT) && (m_ack || cnt_tc));
   assign done_err = (state == WAIT) && !m_ack && cnt_tc;

   mem_arb_timeout_cnt #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .sys_clk(sys_clk),
      .rst_n  (rst_n),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .tc     (cnt_tc)
   );

   // Grant selection among the requests present this cycle
   always_comb begin
      winner = OWN_DATA;
`ifdef ARB_ROUND_ROBIN_EN
      if (i_stb && d_stb) begin
         winner = (last_grant == OWN_DATA) ? OWN_INSTR : OWN_DATA;
      end else if (i_stb) begin
         winner = OWN_INSTR;
      end
`else
      if (!d_stb) begin
         winner = OWN_INSTR;
      end
`endif
   end

   // Transaction sequencer with registered master and response outputs
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         owner   <= OWN_DATA;
         m_cyc   <= 1'b0;
         m_stb   <= 1'b0;
         m_we    <= 1'b0;
         m_sel   <= '0;
         m_addr  <= '0;
         m_wdata <= '0;
         i_ack   <= 1'b0;
         i_err   <= 1'b0;
         d_ack   <= 1'b0;
         d_err   <= 1'b0;
         i_rdata <= '0;
         d_rdata <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant <= OWN_INSTR;
`endif
      end else begin
         i_ack <= 1'b0;
         i_err <= 1'b0;
         d_ack <= 1'b0;
         d_err <= 1'b0;
         case (state)
            IDLE: begin
               if (i_stb || d_stb) begin
                  owner <= winner;
                  state <= ISSUE;
                  m_cyc <= 1'b1;
                  m_stb <= 1'b1;
                  if (winner == OWN_DATA) begin
                     m_we    <= d_we;
                     m_sel   <= d_sel;
                     m_addr  <= d_addr;
                     m_wdata <= d_wdata;
                  end else begin
                     m_we    <= 1'b0;
                     m_sel   <= FETCH_SEL;
                     m_addr  <= i_addr;
                     m_wdata <= '0;
                  end
`ifdef ARB_ROUND_ROBIN_EN
                  last_grant <= winner;
`endif
               end
            end
            ISSUE: begin
               m_stb <= 1'b0;
               state <= m_ack ? RESP : WAIT;
            end
            WAIT: begin
               if (done) begin
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // Completion: close the bus cycle and pulse the owner's response;
         // read data is captured straight into the owner's rdata register
         if (done) begin
            m_cyc <= 1'b0;
            if (owner == OWN_DATA) begin
               d_ack   <= !done_err;
               d_err   <= done_err;
               d_rdata <= done_err ? '0 : m_rdata;
            end else begin
               i_ack   <= !done_err;
               i_err   <= done_err;
               i_rdata <= done_err ? '0 : m_rdata;
            end
         end
      end
   end

endmodule
